// File: rtl/integral_image_gen.sv
// Streaming integral-image writer: consumes row-major 8-bit pixels of one tile
// and emits I(x,y) with a one-row line buffer and a running row sum.
module integral_image_gen #(
  parameter int MAX_WIDTH = 256,
  parameter int PIX_W     = 8,
  parameter int SUM_W     = 32,
  parameter int DIM_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIM_W-1:0] img_width,
  input  logic [DIM_W-1:0] img_height,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  output logic             int_valid,
  input  logic             int_ready,
  output logic [SUM_W-1:0] int_data,
  output logic             int_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int ADDR_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  logic [DIM_W-1:0]   r_w_m1;
  logic [DIM_W-1:0]   r_h_m1;
  logic [DIM_W-1:0]   r_x;
  logic [DIM_W-1:0]   r_y;
  logic [SUM_W-1:0]   r_row_sum;
  logic               r_int_valid;
  logic [SUM_W-1:0]   r_int_data;
  logic               r_int_last;
  logic               r_done;
  logic               r_err;
  logic [SUM_W-1:0]   r_lbuf [0:MAX_WIDTH-1];

  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_x_end;
  logic               w_y_end;
  logic               w_bad_dims;
  logic [ADDR_W-1:0]  w_addr;
  logic [SUM_W-1:0]   w_left;
  logic [SUM_W-1:0]   w_up;
  logic [SUM_W-1:0]   w_rs;
  logic [SUM_W-1:0]   w_sum;

  assign pix_ready = (r_state == S_RUN) && (!r_int_valid || int_ready);
  assign w_in_hs   = pix_valid && pix_ready;
  assign w_out_hs  = r_int_valid && int_ready;
  assign w_x_end   = (r_x == r_w_m1);
  assign w_y_end   = (r_y == r_h_m1);
  assign w_addr    = r_x[ADDR_W-1:0];
  assign w_bad_dims = (img_width == {DIM_W{1'b0}}) || (img_height == {DIM_W{1'b0}}) ||
                      (img_width > DIM_W'(MAX_WIDTH));

  assign int_valid = r_int_valid;
  assign int_data  = r_int_data;
  assign int_last  = r_int_last;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign err       = r_err;

  // Row 0 and column 0 mask stale state, so the line buffer never needs clearing.
  always_comb begin
    w_left = {SUM_W{1'b0}};
    w_up   = {SUM_W{1'b0}};
    if (r_x == {DIM_W{1'b0}}) begin
      w_left = {SUM_W{1'b0}};
    end else begin
      w_left = r_row_sum;
    end
    if (r_y == {DIM_W{1'b0}}) begin
      w_up = {SUM_W{1'b0}};
    end else begin
      w_up = r_lbuf[w_addr];
    end
    w_rs  = w_left + SUM_W'(pix_data);
    w_sum = w_rs + w_up;
  end

  // Line buffer holds the previous row's integral values, one per column.
  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      r_lbuf[w_addr] <= w_sum;
    end
  end

  // Frame FSM, pixel counters and registered output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_w_m1      <= {DIM_W{1'b0}};
      r_h_m1      <= {DIM_W{1'b0}};
      r_x         <= {DIM_W{1'b0}};
      r_y         <= {DIM_W{1'b0}};
      r_row_sum   <= {SUM_W{1'b0}};
      r_int_valid <= 1'b0;
      r_int_data  <= {SUM_W{1'b0}};
      r_int_last  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_in_hs) begin
        r_int_valid <= 1'b1;
        r_int_data  <= w_sum;
        r_int_last  <= w_x_end && w_y_end;
      end else if (w_out_hs) begin
        r_int_valid <= 1'b0;
        r_int_last  <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_bad_dims) begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_err     <= 1'b0;
              r_w_m1    <= img_width - DIM_W'(1);
              r_h_m1    <= img_height - DIM_W'(1);
              r_x       <= {DIM_W{1'b0}};
              r_y       <= {DIM_W{1'b0}};
              r_row_sum <= {SUM_W{1'b0}};
              r_state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_in_hs) begin
            r_row_sum <= w_rs;
            if (w_x_end) begin
              r_x <= {DIM_W{1'b0}};
              if (w_y_end) begin
                r_state <= S_DRAIN;
              end else begin
                r_y <= r_y + DIM_W'(1);
              end
            end else begin
              r_x <= r_x + DIM_W'(1);
            end
          end
        end
        S_DRAIN: begin
          // Only the final value can be pending here; its handshake ends the frame.
          if (w_out_hs) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_integral_image_gen.sv
// Directed testbench for integral_image_gen with hand-computed integral values.
module tb_integral_image_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] img_width;
  logic [15:0] img_height;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic        int_valid;
  logic        int_ready;
  logic [31:0] int_data;
  logic        int_last;
  logic        busy;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  tb_pix   [0:63];
  logic [31:0] cap_data [0:63];
  logic        cap_last [0:63];
  int          cap_n;
  int          done_cnt;
  int          stall_viol;

  integral_image_gen dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .img_width  (img_width),
    .img_height (img_height),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .int_valid  (int_valid),
    .int_ready  (int_ready),
    .int_data   (int_data),
    .int_last   (int_last),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic do_start(input logic [15:0] w, input logic [15:0] h);
    @(negedge clk);
    start = 1'b1; img_width = w; img_height = h;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives n pixels from tb_pix, captures every output handshake; int_ready low in stall window.
  task automatic stream(input int n, input int stall_at, input int stall_len);
    int pi;
    int cyc;
    logic [31:0] held_data;
    logic held_ok;
    pi = 0; cyc = 0; cap_n = 0; done_cnt = 0; stall_viol = 0;
    held_ok = 1'b0; held_data = 32'd0;
    while ((cap_n < n) && (cyc < 500)) begin
      @(negedge clk);
      int_ready = !((cyc >= stall_at) && (cyc < stall_at + stall_len));
      pix_valid = (pi < n);
      pix_data  = (pi < n) ? tb_pix[pi] : 8'd0;
      #1;
      if (!int_ready) begin
        if (pix_ready) stall_viol++;
        if (held_ok && (!int_valid || int_data !== held_data)) stall_viol++;
        held_data = int_data;
        held_ok   = int_valid;
      end else begin
        held_ok = 1'b0;
      end
      if (pix_valid && pix_ready) pi++;
      if (int_valid && int_ready) begin
        cap_data[cap_n] = int_data;
        cap_last[cap_n] = int_last;
        cap_n++;
      end
      if (done) done_cnt++;
      cyc++;
    end
  endtask

  task automatic check_done_pulse(input string name);
    @(negedge clk);
    pix_valid = 1'b0;
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL %s_done: done=%0b busy=%0b early_done=%0d, required done=1 busy=0 early_done=0",
               name, done, busy, done_cnt);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_width: done=%0b, required 0 after one cycle", name, done);
    end
  endtask

  task automatic check_seq(input string name, input int n, input logic [31:0] exp_v [0:15]);
    n_tests++;
    if (cap_n != n) begin
      n_fail++;
      $display("FAIL %s_count: got %0d outputs, required %0d", name, cap_n, n);
    end
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (cap_data[i] !== exp_v[i] || cap_last[i] !== (i == n - 1)) begin
        n_fail++;
        $display("FAIL %s[%0d]: data=%0d last=%0b, required data=%0d last=%0b",
                 name, i, cap_data[i], cap_last[i], exp_v[i], (i == n - 1));
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if (pix_ready !== 1'b0 || int_valid !== 1'b0 || int_data !== 32'd0 || int_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%0b v=%0b d=%0d l=%0b busy=%0b done=%0b err=%0b, required all 0",
               pix_ready, int_valid, int_data, int_last, busy, done, err);
    end
  endtask

  task automatic test_basic();
    logic [31:0] e [0:15];
    e = '{default: 32'd0};
    e[0] = 32'd1; e[1] = 32'd2; e[2] = 32'd3; e[3] = 32'd2; e[4] = 32'd4; e[5] = 32'd6;
    for (int i = 0; i < 6; i++) tb_pix[i] = 8'd1;
    do_start(16'd3, 16'd2);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: busy=%0b, required 1", busy);
    end
    stream(6, 1000, 0);
    check_seq("basic", 6, e);
    check_done_pulse("basic");
  endtask

  task automatic test_saturated();
    logic [31:0] e [0:15];
    e = '{default: 32'd0};
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        e[y*4+x] = 32'd255 * (x + 1) * (y + 1);
    for (int i = 0; i < 16; i++) tb_pix[i] = 8'd255;
    do_start(16'd4, 16'd4);
    stream(16, 1000, 0);
    check_seq("sat255", 16, e);
    n_tests++;
    if (cap_data[3] !== 32'd1020 || cap_data[15] !== 32'd4080) begin
      n_fail++;
      $display("FAIL sat255_corners: row0_end=%0d last=%0d, required 1020 and 4080",
               cap_data[3], cap_data[15]);
    end
    check_done_pulse("sat255");
  endtask

  task automatic test_backpressure();
    logic [31:0] e [0:15];
    e = '{default: 32'd0};
    e[0] = 32'd1; e[1] = 32'd2; e[2] = 32'd3; e[3] = 32'd2; e[4] = 32'd4; e[5] = 32'd6;
    for (int i = 0; i < 6; i++) tb_pix[i] = 8'd1;
    do_start(16'd3, 16'd2);
    stream(6, 2, 5);
    check_seq("bp", 6, e);
    n_tests++;
    if (stall_viol != 0) begin
      n_fail++;
      $display("FAIL bp_stall: %0d stall violations, required 0", stall_viol);
    end
    check_done_pulse("bp");
  endtask

  task automatic test_bad_dims();
    logic [31:0] e [0:15];
    logic [15:0] bad_w [0:1];
    bad_w[0] = 16'd0; bad_w[1] = 16'd257;
    for (int k = 0; k < 2; k++) begin
      do_start(bad_w[k], 16'd2);
      #1;
      n_tests++;
      if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0 || pix_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_dims_w%0d: done=%0b err=%0b busy=%0b rdy=%0b, required 1 1 0 0",
                 bad_w[k], done, err, busy, pix_ready);
      end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || err !== 1'b1) begin
        n_fail++;
        $display("FAIL bad_dims_hold_w%0d: done=%0b err=%0b, required done=0 err=1", bad_w[k], done, err);
      end
    end
    do_start(16'd2, 16'd0);
    #1;
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_dims_h0: err=%0b busy=%0b, required err=1 busy=0", err, busy);
    end
    do_start(16'd2, 16'd1);
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_dims_clear: err=%0b busy=%0b, required err=0 busy=1", err, busy);
    end
    e = '{default: 32'd0};
    e[0] = 32'd5; e[1] = 32'd11;
    tb_pix[0] = 8'd5; tb_pix[1] = 8'd6;
    stream(2, 1000, 0);
    check_seq("after_bad", 2, e);
    check_done_pulse("after_bad");
  endtask

  task automatic test_back_to_back();
    logic [31:0] e [0:15];
    for (int i = 0; i < 9; i++) tb_pix[i] = 8'd9;
    do_start(16'd3, 16'd3);
    stream(9, 1000, 0);
    n_tests++;
    if (cap_n != 9 || cap_data[8] !== 32'd81 || cap_data[4] !== 32'd36) begin
      n_fail++;
      $display("FAIL b2b_frameA: n=%0d mid=%0d last=%0d, required 9, 36, 81",
               cap_n, cap_data[4], cap_data[8]);
    end
    check_done_pulse("b2b_A");
    e = '{default: 32'd0};
    e[0] = 32'd1; e[1] = 32'd3; e[2] = 32'd4; e[3] = 32'd10;
    tb_pix[0] = 8'd1; tb_pix[1] = 8'd2; tb_pix[2] = 8'd3; tb_pix[3] = 8'd4;
    do_start(16'd2, 16'd2);
    stream(4, 1000, 0);
    check_seq("b2b_B", 4, e);
    check_done_pulse("b2b_B");
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] e [0:15];
    do_start(16'd3, 16'd3);
    int_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pix_valid = 1'b1; pix_data = 8'd7;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    #1;
    n_tests++;
    if (int_valid !== 1'b1 || int_data !== 32'd21) begin
      n_fail++;
      $display("FAIL midrst_pre: v=%0b d=%0d, required v=1 d=21", int_valid, int_data);
    end
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if (int_valid !== 1'b0 || int_data !== 32'd0 || int_last !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || pix_ready !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: v=%0b d=%0d l=%0b busy=%0b done=%0b rdy=%0b err=%0b, required all 0",
               int_valid, int_data, int_last, busy, done, pix_ready, err);
    end
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    n_tests++;
    if (done_cnt != 0) begin
      n_fail++;
      $display("FAIL midrst_idle: %0d cycles with done/busy, required 0", done_cnt);
    end
    e = '{default: 32'd0};
    e[0] = 32'd1; e[1] = 32'd2; e[2] = 32'd3;
    e[3] = 32'd2; e[4] = 32'd4; e[5] = 32'd6;
    e[6] = 32'd3; e[7] = 32'd6; e[8] = 32'd9;
    for (int i = 0; i < 9; i++) tb_pix[i] = 8'd1;
    do_start(16'd3, 16'd3);
    stream(9, 1000, 0);
    check_seq("midrst_new", 9, e);
    check_done_pulse("midrst_new");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; img_width = 16'd0; img_height = 16'd0;
    pix_valid = 1'b0; pix_data = 8'd0; int_ready = 1'b1;
    test_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_basic();
    test_saturated();
    test_backpressure();
    test_bad_dims();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
